tdm_demux8: RTL and testbench

- Receive-side counterpart of the 8:1 select mux when that mux is driven by a slot counter as a time-division serializer.
- Takes a 1-bit slot-multiplexed stream with a frame-start marker and steers each bit into lane `in[sel]` of an 8-bit frame register.
- Presents each completed frame on a valid/ready output with a one-deep holding buffer.
- Sits between a serial link and any consumer of the parallel 8-lane word.

---
 rtl/tdm_demux8.sv | 103 ++++++++++
 tb/tb_tdm_demux8.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: steers a slot-multiplexed serial stream into an
// 8-lane frame with a one-deep valid/ready output buffer. Optional: TDM_DEMUX_PARITY_EN.
module tdm_demux8 #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned LANES = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [LANES-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef TDM_DEMUX_PARITY_EN
    output logic [SEL_W:0]   slot,
    output logic             parity_err,
`else
    output logic [SEL_W-1:0] slot,
`endif
    output logic             overflow,
    output logic             sync_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned SLOT_W = SEL_W + 1;
    localparam int unsigned LAST   = LANES;
`else
    localparam int unsigned SLOT_W = SEL_W;
    localparam int unsigned LAST   = LANES - 1;
`endif

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state;
    logic [LANES-1:0] shift;
    logic [LANES-1:0] frame;
    logic             done;
`ifdef TDM_DEMUX_PARITY_EN
    logic             frame_perr;
`endif

    // The final beat is merged combinationally so the frame is offered in the same cycle.
    always_comb begin
        done  = in_valid && !frame_start && (state == COLLECT) && (slot == SLOT_W'(LAST));
        frame = shift;
`ifdef TDM_DEMUX_PARITY_EN
        frame_perr = ^{shift, in_bit};
`else
        frame[LANES-1] = in_bit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot      <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overflow <= 1'b0;
            sync_err <= 1'b0;

            if (in_valid) begin
                if (frame_start) begin
                    sync_err <= (state == COLLECT);
                    shift[0] <= in_bit;
                    slot     <= SLOT_W'(1);
                    state    <= COLLECT;
                end else if (state == COLLECT) begin
                    if (done) begin
                        slot  <= '0;
                        state <= IDLE;
                    end else begin
                        shift[slot[SEL_W-1:0]] <= in_bit;
                        slot <= slot + 1'b1;
                    end
                end
            end

            if (done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= frame;
                    out_valid <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                    parity_err <= frame_perr;
`endif
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized and directed bench for tdm_demux8 against a frame-level reference model.
// Honours TDM_DEMUX_PARITY_EN when defined.
module tb_tdm_demux8;

    localparam int SEL_W = 3;
    localparam int LANES = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FLEN = LANES + 1;
    localparam int SW   = SEL_W + 1;
`else
    localparam int FLEN = LANES;
    localparam int SW   = SEL_W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic frame_start = 1'b0;
    logic out_ready = 1'b0;
    logic [LANES-1:0] out_data;
    logic out_valid;
    logic overflow;
    logic sync_err;
    logic [SW-1:0] slot;
`ifdef TDM_DEMUX_PARITY_EN
    logic parity_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: bits received so far in the frame and the output buffer contents.
    int               m_pos;
    logic             m_bits [LANES+1];
    logic [LANES-1:0] m_data;
    logic             m_valid, m_ovf, m_sync, m_perr;

    tdm_demux8 #(.SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .frame_start(frame_start), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .slot(slot),
`ifdef TDM_DEMUX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overflow(overflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pos = 0; m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_sync = 1'b0; m_perr = 1'b0;
        for (int k = 0; k <= LANES; k++) m_bits[k] = 1'b0;
    endfunction

    function automatic void model_step(input logic b, input logic v, input logic fs, input logic rdy);
        logic done;
        int   value;
        int   ones;
        done = 1'b0;
        m_ovf = 1'b0;
        m_sync = 1'b0;
        if (v) begin
            if (fs) begin
                if (m_pos > 0) m_sync = 1'b1;
                m_bits[0] = b;
                m_pos = 1;
            end else if (m_pos > 0) begin
                m_bits[m_pos] = b;
                m_pos = m_pos + 1;
                if (m_pos == FLEN) begin
                    done = 1'b1;
                    m_pos = 0;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                value = 0;
                ones = 0;
                for (int k = 0; k < LANES; k++) begin
                    value = value + (int'(m_bits[k]) << k);
                    ones = ones + int'(m_bits[k]);
                end
                m_data = LANES'(value);
                m_valid = 1'b1;
                m_perr = ((ones + int'(m_bits[LANES])) % 2) == 1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic drive(input logic b, input logic v, input logic fs, input logic rdy);
        in_bit = b; in_valid = v; frame_start = fs; out_ready = rdy;
        @(posedge clk);
        model_step(b, v, fs, rdy);
        #1;
    endtask

    function automatic logic fbit(input logic [7:0] d, input int k, input logic pbit);
        logic [7:0] t;
        t = d >> k;
        return (k < LANES) ? t[0] : pbit;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic rdy,
                              output int syncs, output int ovfs);
        syncs = 0;
        ovfs = 0;
        for (int k = 0; k < FLEN; k++) begin
            drive(fbit(d, k, pbit), 1'b1, k == 0, rdy);
            syncs += int'(sync_err);
            ovfs += int'(overflow);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
        checks++; if (slot !== '0) begin errors++; $display("FAIL reset_slot got %0d exp 0", slot); end
        checks++; if ({overflow, sync_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {overflow, sync_err}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        for (int k = 0; k < FLEN - 1; k++) drive(fbit(8'hAA, k, 1'b0), 1'b1, k == 0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
        checks++; if (slot !== SW'(FLEN - 1)) begin errors++; $display("FAIL single_slot got %0d exp %0d", slot, FLEN - 1); end
        drive(fbit(8'hAA, FLEN - 1, 1'b0), 1'b1, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL single_data got %h exp AA", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", overflow); end
        checks++; if (slot !== '0) begin errors++; $display("FAIL single_slot_wrap got %0d exp 0", slot); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int s, o;
        logic [7:0] d;
        send_frame(8'h0F, 1'b0, 1'b1, s, o);
        checks++; if (out_data !== 8'h0F || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 0F/1", out_data, out_valid); end
        send_frame(8'hF0, 1'b0, 1'b1, s, o);
        checks++; if (out_data !== 8'hF0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp F0/1", out_data, out_valid); end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_frame(d, ^d, 1'b1, s, o);
            checks++; if (out_data !== d || out_data !== m_data || out_valid !== 1'b1 || o != 0 || s != 0)
                begin errors++; $display("FAIL b2b_rand got %h/%b ovf %0d sync %0d exp %h/1 0 0", out_data, out_valid, o, s, d); end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        int s, o;
        send_frame(8'h55, 1'b0, 1'b0, s, o);
        checks++; if (out_data !== 8'h55 || out_valid !== 1'b1 || o != 0) begin errors++; $display("FAIL ovf_first got %h/%b ovf %0d exp 55/1 0", out_data, out_valid, o); end
        send_frame(8'h33, 1'b0, 1'b0, s, o);
        checks++; if (overflow !== 1'b1 || o != 1) begin errors++; $display("FAIL ovf_pulse got %b count %0d exp 1 1", overflow, o); end
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL ovf_hold got %h exp 55", out_data); end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_after got %b/%b exp 0/1", overflow, out_valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h55) begin errors++; $display("FAIL ovf_consume got %b/%h exp 0/55", out_valid, out_data); end
    endtask

    task automatic test_resync();
        int s, o;
        drive(1'($urandom), 1'b1, 1'b1, 1'b1);
        drive(1'($urandom), 1'b1, 1'b0, 1'b1);
        drive(1'($urandom), 1'b1, 1'b0, 1'b1);
        checks++; if (slot !== SW'(3)) begin errors++; $display("FAIL resync_slot got %0d exp 3", slot); end
        send_frame(8'hC3, 1'b0, 1'b1, s, o);
        checks++; if (s != 1) begin errors++; $display("FAIL resync_pulses got %0d exp 1", s); end
        checks++; if (out_data !== 8'hC3 || out_valid !== 1'b1) begin errors++; $display("FAIL resync_data got %h/%b exp C3/1", out_data, out_valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_idle_reset();
        int s, o;
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'b1, 1'b0, 1'b1);
            checks++; if (slot !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore got slot %0d valid %b exp 0 0", slot, out_valid); end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++; if ({out_valid, overflow, sync_err} !== 3'b000 || out_data !== '0 || slot !== '0)
            begin errors++; $display("FAIL midreset got data %h valid %b ovf %b sync %b slot %0d exp all 0", out_data, out_valid, overflow, sync_err, slot); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, s, o);
        checks++; if (out_data !== 8'h81 || out_valid !== 1'b1 || s != 0) begin errors++; $display("FAIL post_reset got %h/%b sync %0d exp 81/1 0", out_data, out_valid, s); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        int s, o;
        send_frame(8'hAA, 1'b0, 1'b1, s, o);
        checks++; if (parity_err !== 1'b0 || out_data !== 8'hAA) begin errors++; $display("FAIL parity_good got %b/%h exp 0/AA", parity_err, out_data); end
        send_frame(8'hAA, 1'b1, 1'b1, s, o);
        checks++; if (parity_err !== 1'b1 || out_data !== 8'hAA) begin errors++; $display("FAIL parity_bad got %b/%h exp 1/AA", parity_err, out_data); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || overflow !== m_ovf ||
                sync_err !== m_sync || slot !== SW'(m_pos)
`ifdef TDM_DEMUX_PARITY_EN
                || parity_err !== m_perr
`endif
                ) begin
                errors++;
                $display("FAIL random cycle %0d got v%b d%h o%b s%b slot%0d exp v%b d%h o%b s%b slot%0d",
                         i, out_valid, out_data, overflow, sync_err, slot,
                         m_valid, m_data, m_ovf, m_sync, m_pos);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_resync();
        test_idle_reset();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
